// File: rtl/jtag_vio_responder_if.sv
// Override / readback bus between the JTAG VIO responder and the pixel path.
// The responder drives the override value, its enable and the update strobe;
// the consumer supplies the live values that the host reads back.
interface jtag_vio_responder_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] probe_in;
    logic [DATA_W-1:0] vio_data;
    logic              vio_en;
    logic              update_stb;

    modport master (
        input  probe_in,
        output vio_data,
        output vio_en,
        output update_stb
    );

    modport slave (
        output probe_in,
        input  vio_data,
        input  vio_en,
        input  update_stb
    );
endinterface

// File: rtl/jtag_vio_responder.sv
// JTAG virtual I/O responder.
// The raw JTAG pins are oversampled in the LCD_CLK domain and drive a full
// 1149.1 TAP controller. One user data register (DATA_W data bits plus an
// enable bit on top) lets the host override the isam dout lanes and read
// back the live values. All other instruction codes select BYPASS.
module jtag_vio_responder #(
    parameter int              DATA_W      = 4,
    parameter int              IR_W        = 4,
    parameter logic [IR_W-1:0] USER_IR     = 4'hA,
    parameter int              SYNC_STAGES = 2
) (
    input  logic                 LCD_CLK,
    input  logic                 nRST,
    input  logic                 tck_i,
    input  logic                 tms_i,
    input  logic                 tdi_i,
    output logic                 tdo_o,
    output logic                 tdo_oe,
    output logic [3:0]           tap_state,
    jtag_vio_responder_if.master vio
);

    // Test-Logic-Reset is encoded as zero so the reset value of every
    // output, including the debug state bus, is all zeros.
    typedef enum logic [3:0] {
        ST_TLR        = 4'd0,
        ST_RTI        = 4'd1,
        ST_SEL_DR     = 4'd2,
        ST_CAPTURE_DR = 4'd3,
        ST_SHIFT_DR   = 4'd4,
        ST_EXIT1_DR   = 4'd5,
        ST_PAUSE_DR   = 4'd6,
        ST_EXIT2_DR   = 4'd7,
        ST_UPDATE_DR  = 4'd8,
        ST_SEL_IR     = 4'd9,
        ST_CAPTURE_IR = 4'd10,
        ST_SHIFT_IR   = 4'd11,
        ST_EXIT1_IR   = 4'd12,
        ST_PAUSE_IR   = 4'd13,
        ST_EXIT2_IR   = 4'd14,
        ST_UPDATE_IR  = 4'd15
    } tap_state_t;

    logic [SYNC_STAGES-1:0] tck_sync_r;
    logic [SYNC_STAGES-1:0] tms_sync_r;
    logic [SYNC_STAGES-1:0] tdi_sync_r;
    logic                   tck_dly_r;

    logic tck_s;
    logic tms_s;
    logic tdi_s;
    logic tck_rise_s;
    logic tck_fall_s;

    tap_state_t state_r;
    tap_state_t state_next_s;

    logic [IR_W-1:0]   ir_r;
    logic [IR_W-1:0]   ir_shift_r;
    logic [DATA_W:0]   dr_shift_r;
    logic              bypass_r;
    logic [DATA_W-1:0] vio_data_r;
    logic              vio_en_r;
    logic              update_stb_r;
    logic              tdo_r;
    logic              tdo_oe_r;
    logic              tdo_next_s;
    logic              tdo_oe_next_s;
    logic              user_sel_s;
    logic              enter_tlr_s;

    // tms and tdi are taken from the same stage as tck so they stay aligned.
    assign tck_s      = tck_sync_r[SYNC_STAGES-1];
    assign tms_s      = tms_sync_r[SYNC_STAGES-1];
    assign tdi_s      = tdi_sync_r[SYNC_STAGES-1];
    assign tck_rise_s = tck_s & ~tck_dly_r;
    assign tck_fall_s = ~tck_s & tck_dly_r;

    assign user_sel_s  = (ir_r == USER_IR);
    assign enter_tlr_s = tck_rise_s && (state_next_s == ST_TLR);

    // Synchronise the asynchronous JTAG pins and keep one delayed tck sample.
    always_ff @(posedge LCD_CLK or negedge nRST) begin
        if (!nRST) begin
            tck_sync_r <= {SYNC_STAGES{1'b0}};
            tms_sync_r <= {SYNC_STAGES{1'b0}};
            tdi_sync_r <= {SYNC_STAGES{1'b0}};
            tck_dly_r  <= 1'b0;
        end else begin
            tck_sync_r <= {tck_sync_r[SYNC_STAGES-2:0], tck_i};
            tms_sync_r <= {tms_sync_r[SYNC_STAGES-2:0], tms_i};
            tdi_sync_r <= {tdi_sync_r[SYNC_STAGES-2:0], tdi_i};
            tck_dly_r  <= tck_s;
        end
    end

    // TAP state register.
    always_ff @(posedge LCD_CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_TLR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // TAP next-state logic; the state only moves on a synchronised tck rise.
    always_comb begin
        state_next_s = state_r;
        if (tck_rise_s) begin
            case (state_r)
                ST_TLR:        state_next_s = tms_s ? ST_TLR       : ST_RTI;
                ST_RTI:        state_next_s = tms_s ? ST_SEL_DR    : ST_RTI;
                ST_SEL_DR:     state_next_s = tms_s ? ST_SEL_IR    : ST_CAPTURE_DR;
                ST_CAPTURE_DR: state_next_s = tms_s ? ST_EXIT1_DR  : ST_SHIFT_DR;
                ST_SHIFT_DR:   state_next_s = tms_s ? ST_EXIT1_DR  : ST_SHIFT_DR;
                ST_EXIT1_DR:   state_next_s = tms_s ? ST_UPDATE_DR : ST_PAUSE_DR;
                ST_PAUSE_DR:   state_next_s = tms_s ? ST_EXIT2_DR  : ST_PAUSE_DR;
                ST_EXIT2_DR:   state_next_s = tms_s ? ST_UPDATE_DR : ST_SHIFT_DR;
                ST_UPDATE_DR:  state_next_s = tms_s ? ST_SEL_DR    : ST_RTI;
                ST_SEL_IR:     state_next_s = tms_s ? ST_TLR       : ST_CAPTURE_IR;
                ST_CAPTURE_IR: state_next_s = tms_s ? ST_EXIT1_IR  : ST_SHIFT_IR;
                ST_SHIFT_IR:   state_next_s = tms_s ? ST_EXIT1_IR  : ST_SHIFT_IR;
                ST_EXIT1_IR:   state_next_s = tms_s ? ST_UPDATE_IR : ST_PAUSE_IR;
                ST_PAUSE_IR:   state_next_s = tms_s ? ST_EXIT2_IR  : ST_PAUSE_IR;
                ST_EXIT2_IR:   state_next_s = tms_s ? ST_UPDATE_IR : ST_SHIFT_IR;
                ST_UPDATE_IR:  state_next_s = tms_s ? ST_SEL_DR    : ST_RTI;
                default:       state_next_s = ST_TLR;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Instruction path: capture pattern, LSB-first shift, and update into IR.
    always_ff @(posedge LCD_CLK or negedge nRST) begin
        if (!nRST) begin
            ir_r       <= {IR_W{1'b1}};
            ir_shift_r <= {IR_W{1'b0}};
        end else if (tck_rise_s) begin
            case (state_r)
                ST_CAPTURE_IR: ir_shift_r <= {{(IR_W-2){1'b0}}, 2'b01};
                ST_SHIFT_IR:   ir_shift_r <= {tdi_s, ir_shift_r[IR_W-1:1]};
                ST_UPDATE_IR:  ir_r       <= ir_shift_r;
                default:       ir_shift_r <= ir_shift_r;
            endcase
            if (enter_tlr_s) begin
                ir_r <= {IR_W{1'b1}};
            end
        end
    end

    // Data path: user DR / BYPASS capture and shift, override update and strobe.
    always_ff @(posedge LCD_CLK or negedge nRST) begin
        if (!nRST) begin
            dr_shift_r   <= {(DATA_W+1){1'b0}};
            bypass_r     <= 1'b0;
            vio_data_r   <= {DATA_W{1'b0}};
            vio_en_r     <= 1'b0;
            update_stb_r <= 1'b0;
        end else begin
            update_stb_r <= 1'b0;
            if (tck_rise_s) begin
                case (state_r)
                    ST_CAPTURE_DR: begin
                        if (user_sel_s) dr_shift_r <= {vio_en_r, vio.probe_in};
                        else            bypass_r   <= 1'b0;
                    end
                    ST_SHIFT_DR: begin
                        if (user_sel_s) dr_shift_r <= {tdi_s, dr_shift_r[DATA_W:1]};
                        else            bypass_r   <= tdi_s;
                    end
                    ST_UPDATE_DR: begin
                        if (user_sel_s) begin
                            vio_data_r   <= dr_shift_r[DATA_W-1:0];
                            vio_en_r     <= dr_shift_r[DATA_W];
                            update_stb_r <= 1'b1;
                        end
                    end
                    default: dr_shift_r <= dr_shift_r;
                endcase
                // Leaving override mode on a TAP reset; the last value is kept.
                if (enter_tlr_s) begin
                    vio_en_r <= 1'b0;
                end
            end
        end
    end

    // Select what tdo presents after the next falling tck edge.
    always_comb begin
        tdo_next_s    = 1'b0;
        tdo_oe_next_s = 1'b0;
        if (state_r == ST_SHIFT_IR) begin
            tdo_next_s    = ir_shift_r[0];
            tdo_oe_next_s = 1'b1;
        end else if (state_r == ST_SHIFT_DR) begin
            tdo_next_s    = user_sel_s ? dr_shift_r[0] : bypass_r;
            tdo_oe_next_s = 1'b1;
        end else begin
            tdo_next_s    = 1'b0;
            tdo_oe_next_s = 1'b0;
        end
    end

    // tdo and its enable change only on a synchronised tck fall.
    always_ff @(posedge LCD_CLK or negedge nRST) begin
        if (!nRST) begin
            tdo_r    <= 1'b0;
            tdo_oe_r <= 1'b0;
        end else if (tck_fall_s) begin
            tdo_r    <= tdo_next_s;
            tdo_oe_r <= tdo_oe_next_s;
        end
    end

    assign tdo_o          = tdo_r;
    assign tdo_oe         = tdo_oe_r;
    assign tap_state      = state_r;
    assign vio.vio_data   = vio_data_r;
    assign vio.vio_en     = vio_en_r;
    assign vio.update_stb = update_stb_r;

endmodule

// File: tb/tb_jtag_vio_responder.sv
// Self-checking bench for jtag_vio_responder: hand-computed vector table,
// directed pause / TAP-reset / async-reset sequences, and random JTAG
// operations checked every TCK cycle against a behavioural TAP model.
module tb_jtag_vio_responder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tck   = 1'b0;
    logic       tms   = 1'b0;
    logic       tdi   = 1'b0;
    logic       tdo;
    logic       tdo_oe;
    logic [3:0] tap_state;
    logic [3:0] probe = 4'd0;

    int n_tests = 0;
    int n_fail  = 0;

    jtag_vio_responder_if #(.DATA_W(4)) vif ();
    assign vif.probe_in = probe;

    jtag_vio_responder #(
        .DATA_W(4), .IR_W(4), .USER_IR(4'hA), .SYNC_STAGES(2)
    ) dut (
        .LCD_CLK  (clk),
        .nRST     (rst_n),
        .tck_i    (tck),
        .tms_i    (tms),
        .tdi_i    (tdi),
        .tdo_o    (tdo),
        .tdo_oe   (tdo_oe),
        .tap_state(tap_state),
        .vio      (vif.master)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts pulses and any pulse lasting more than one cycle.
    int   stb_cnt  = 0;
    int   stb_long = 0;
    logic stb_prev = 1'b0;
    always @(negedge clk) begin
        stb_prev <= vif.update_stb;
        if (vif.update_stb && !stb_prev) stb_cnt  <= stb_cnt + 1;
        if (vif.update_stb && stb_prev)  stb_long <= stb_long + 1;
    end

    // ---------------- behavioural model ----------------
    // State numbering follows the tap_state debug encoding (0 = Test-Logic-Reset).
    localparam int TLR = 0, RTI = 1, CAP_DR = 3, SH_DR = 4, UPD_DR = 8;
    localparam int CAP_IR = 10, SH_IR = 11, UPD_IR = 15;
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int         m_st;
    int         m_irsh, m_ir, m_dr, m_byp;
    int         m_vd, m_ven, m_tdo, m_oe;
    int         m_stb = 0;

    task automatic model_reset();
        m_st = TLR; m_ir = 15; m_irsh = 0; m_dr = 0; m_byp = 0;
        m_vd = 0; m_ven = 0; m_tdo = 0; m_oe = 0;
    endtask

    task automatic model_step(input int t_ms, input int t_di);
        int ns;
        if (m_st == CAP_IR) m_irsh = 1;
        if (m_st == SH_IR)  m_irsh = (m_irsh / 2) + t_di * 8;
        if (m_st == UPD_IR) m_ir = m_irsh;
        if (m_ir == 10) begin
            if (m_st == CAP_DR) m_dr = m_ven * 16 + int'(probe);
            if (m_st == SH_DR)  m_dr = (m_dr / 2) + t_di * 16;
            if (m_st == UPD_DR) begin
                m_vd = m_dr % 16; m_ven = m_dr / 16; m_stb = m_stb + 1;
            end
        end else begin
            if (m_st == CAP_DR) m_byp = 0;
            if (m_st == SH_DR)  m_byp = t_di;
        end
        ns = (t_ms != 0) ? nxt1[m_st] : nxt0[m_st];
        if (ns == TLR) begin m_ir = 15; m_ven = 0; end
        m_st  = ns;
        m_oe  = (ns == SH_DR || ns == SH_IR) ? 1 : 0;
        m_tdo = (ns == SH_IR) ? m_irsh % 2 :
                (ns == SH_DR) ? ((m_ir == 10) ? m_dr % 2 : m_byp) : 0;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One TCK period: low phase (sample outputs), then high phase.
    task automatic tck_cycle(input logic t_ms, input logic t_di, output logic t_do);
        int half;
        half = int'($urandom_range(40, 55));
        tck = 1'b0; tms = t_ms; tdi = t_di;
        #(half);
        check("tap_state", 32'(tap_state), 32'(m_st));
        check("tdo_o", 32'(tdo), 32'(m_tdo));
        check("tdo_oe", 32'(tdo_oe), 32'(m_oe));
        check("vio_data", 32'(vif.vio_data), 32'(m_vd));
        check("vio_en", 32'(vif.vio_en), 32'(m_ven));
        check("stb_count", 32'(stb_cnt), 32'(m_stb));
        t_do = tdo;
        tck = 1'b1;
        model_step(int'(t_ms), int'(t_di));
        #(half);
    endtask

    task automatic goto_rti();
        logic d;
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
    endtask

    // From Run-Test/Idle: load an instruction, return the captured bits.
    task automatic shift_ir(input logic [3:0] v, output logic [3:0] cap);
        logic d;
        tck_cycle(1'b1, 1'b0, d); tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d); tck_cycle(1'b0, 1'b0, d);
        for (int i = 0; i < 4; i++) begin
            tck_cycle(i == 3, v[i], d);
            cap[i] = d;
        end
        tck_cycle(1'b1, 1'b0, d); tck_cycle(1'b0, 1'b0, d);
    endtask

    // From Run-Test/Idle: shift a 5-bit DR, optionally pausing after bit pause_at.
    task automatic shift_dr(input logic [4:0] v, input int pause_at, output logic [4:0] cap);
        logic d;
        tck_cycle(1'b1, 1'b0, d); tck_cycle(1'b0, 1'b0, d); tck_cycle(1'b0, 1'b0, d);
        for (int i = 0; i < 5; i++) begin
            tck_cycle((i == 4) || (i == pause_at), v[i], d);
            cap[i] = d;
            if (i == pause_at && i != 4) begin
                for (int k = 0; k < 3; k++) tck_cycle(1'b0, 1'b0, d);
                tck_cycle(1'b1, 1'b0, d);
                tck_cycle(1'b0, 1'b0, d);
            end
        end
        tck_cycle(1'b1, 1'b0, d); tck_cycle(1'b0, 1'b0, d);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] ir;
        logic [4:0] dr;
        logic [3:0] probe;
        logic [3:0] ir_tdo;
        logic [4:0] dr_tdo;
        logic [3:0] vio_data;
        logic       vio_en;
        int         stb_inc;
    } vec_t;
    vec_t vecs [5];

    initial begin
        logic [3:0] cap_ir;
        logic [4:0] cap_dr;
        logic       d;
        int         s0;

        vecs[0] = '{4'hA, 5'b10110, 4'b1001, 4'b0001, 5'b01001, 4'b0110, 1'b1, 1};
        vecs[1] = '{4'hA, 5'b10101, 4'b1001, 4'b0001, 5'b11001, 4'b0101, 1'b1, 1};
        vecs[2] = '{4'h3, 5'b01011, 4'b1001, 4'b0001, 5'b10110, 4'b0101, 1'b1, 0};
        vecs[3] = '{4'hA, 5'b01111, 4'b0000, 4'b0001, 5'b10000, 4'b1111, 1'b0, 1};
        vecs[4] = '{4'hF, 5'b00000, 4'b0110, 4'b0001, 5'b00000, 4'b1111, 1'b0, 0};

        model_reset();
        #(20 + $urandom_range(0, 9));
        check("rst_tap_state", 32'(tap_state), 32'd0);
        check("rst_vio_data", 32'(vif.vio_data), 32'd0);
        check("rst_vio_en", 32'(vif.vio_en), 32'd0);
        check("rst_tdo_oe", 32'(tdo_oe), 32'd0);
        check("rst_stb", 32'(vif.update_stb), 32'd0);
        rst_n = 1'b1;
        #33;

        goto_rti();
        check("tlr_vio_en", 32'(vif.vio_en), 32'd0);

        // Table-driven IR + DR transactions.
        for (int i = 0; i < 5; i++) begin
            probe = vecs[i].probe;
            shift_ir(vecs[i].ir, cap_ir);
            check("ir_capture", 32'(cap_ir), 32'(vecs[i].ir_tdo));
            s0 = stb_cnt;
            shift_dr(vecs[i].dr, 9, cap_dr);
            check("dr_readback", 32'(cap_dr), 32'(vecs[i].dr_tdo));
            check("vec_vio_data", 32'(vif.vio_data), 32'(vecs[i].vio_data));
            check("vec_vio_en", 32'(vif.vio_en), 32'(vecs[i].vio_en));
            check("vec_stb_inc", 32'(stb_cnt - s0), 32'(vecs[i].stb_inc));
        end

        // Pause-DR in the middle of a shift must not lose bits.
        shift_ir(4'hA, cap_ir);
        shift_dr(5'b10011, 2, cap_dr);
        check("pause_vio_data", 32'(vif.vio_data), 32'h3);
        check("pause_vio_en", 32'(vif.vio_en), 32'd1);

        // Five TMS-high clocks: TAP reset clears enable, keeps data.
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, d);
        #60;
        check("tms5_state", 32'(tap_state), 32'd0);
        check("tms5_vio_en", 32'(vif.vio_en), 32'd0);
        check("tms5_vio_data", 32'(vif.vio_data), 32'h3);
        tck_cycle(1'b0, 1'b0, d);

        // Held tck: nothing moves.
        #300;
        check("idle_state", 32'(tap_state), 32'd1);
        check("idle_tdo_oe", 32'(tdo_oe), 32'd0);

        // Asynchronous reset in the middle of Shift-DR.
        shift_ir(4'hA, cap_ir);
        tck_cycle(1'b1, 1'b0, d); tck_cycle(1'b0, 1'b0, d); tck_cycle(1'b0, 1'b0, d);
        tck_cycle(1'b0, 1'b1, d); tck_cycle(1'b0, 1'b1, d);
        s0 = stb_cnt;
        #7 rst_n = 1'b0;
        #3;
        tck = 1'b0;
        check("mid_rst_state", 32'(tap_state), 32'd0);
        check("mid_rst_tdo", 32'(tdo), 32'd0);
        check("mid_rst_tdo_oe", 32'(tdo_oe), 32'd0);
        check("mid_rst_vio_data", 32'(vif.vio_data), 32'd0);
        check("mid_rst_vio_en", 32'(vif.vio_en), 32'd0);
        model_reset();
        #40 rst_n = 1'b1;
        #200;
        check("post_rst_state", 32'(tap_state), 32'd0);
        check("post_rst_no_stb", 32'(stb_cnt - s0), 32'd0);
        tck_cycle(1'b0, 1'b0, d);

        // Random operations checked cycle by cycle against the model.
        for (int n = 0; n < 60; n++) begin
            int op;
            probe = 4'($urandom_range(0, 15));
            op = int'($urandom_range(0, 9));
            if (op < 3) begin
                shift_ir(($urandom_range(0, 1) == 1) ? 4'hA : 4'($urandom_range(0, 15)), cap_ir);
                check("rnd_ir_capture", 32'(cap_ir), 32'h1);
            end else if (op < 8) begin
                shift_dr(5'($urandom_range(0, 31)), int'($urandom_range(0, 6)), cap_dr);
            end else if (op == 8) begin
                goto_rti();
            end else begin
                for (int k = 0; k < 6; k++)
                    tck_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
                goto_rti();
            end
            #($urandom_range(0, 13));
        end

        check("stb_width", 32'(stb_long), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
